// File: rtl/int2float_seq_if.sv
// Handshake bundle for the int2float_seq converter: operand in, IEEE-754 single out.
interface int2float_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_int;
    logic        in_signed;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_float;
    logic        out_inexact;
    logic        out_zero;

    modport master (
        output in_valid, in_int, in_signed, out_ready,
        input  in_ready, out_valid, out_float, out_inexact, out_zero
    );

    modport slave (
        input  in_valid, in_int, in_signed, out_ready,
        output in_ready, out_valid, out_float, out_inexact, out_zero
    );
endinterface

// File: rtl/int2float_seq.sv
// Multi-cycle 32-bit integer -> IEEE-754 single converter (IDLE/NORM/ROUND/DONE).
// Define INT2FLOAT_FAST_NORM_EN for a one-shot leading-zero normalise with fixed latency.
module int2float_seq #(
    parameter int ROUND_MODE = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    int2float_seq_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

    localparam bit RNE = (ROUND_MODE != 1);

    state_t      state, state_nx;
    logic        sign_q;
    logic [31:0] mag_q;
    logic [7:0]  exp_q;
    logic [31:0] out_float_q;
    logic        out_inexact_q;
    logic        out_zero_q;

    logic        sign_in;
    logic [31:0] mag_in;
    logic        hs_in;

    logic [22:0] man, man_r;
    logic        g, s, inc, carry;
    logic [7:0]  exp_r;

    // 0x80000000 signed negates to itself, which is exactly the magnitude we want.
    assign sign_in = bus.in_signed & bus.in_int[31];
    assign mag_in  = sign_in ? (~bus.in_int + 32'd1) : bus.in_int;

    assign bus.in_ready    = (state == IDLE) & rst_n;
    assign bus.out_valid   = (state == DONE);
    assign bus.out_float   = out_float_q;
    assign bus.out_inexact = out_inexact_q;
    assign bus.out_zero    = out_zero_q;

    assign hs_in = bus.in_valid & bus.in_ready;

    // Top bit of the normalised magnitude is the hidden 1; exponent tops out at 159.
    assign man            = mag_q[30:8];
    assign g              = mag_q[7];
    assign s              = |mag_q[6:0];
    assign inc            = RNE & g & (s | man[0]);
    assign {carry, man_r} = {1'b0, man} + {23'd0, inc};
    assign exp_r          = exp_q + {7'd0, carry};

`ifdef INT2FLOAT_FAST_NORM_EN
    logic [5:0] lzc_in, lzc_q;
    logic       norm_done_q;

    function automatic logic [5:0] lzc32(input logic [31:0] v);
        lzc32 = 6'd32;
        for (int i = 0; i < 32; i++)
            if (v[i]) lzc32 = 6'(31 - i);
    endfunction

    assign lzc_in = lzc32(mag_in);
`endif

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (hs_in) state_nx = (mag_in == 32'd0) ? DONE : NORM;
`ifdef INT2FLOAT_FAST_NORM_EN
            NORM:  if (norm_done_q) state_nx = ROUND;
`else
            NORM:  if (mag_q[31]) state_nx = ROUND;
`endif
            ROUND: state_nx = DONE;
            DONE:  if (bus.out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            sign_q        <= 1'b0;
            mag_q         <= 32'd0;
            exp_q         <= 8'd0;
            out_float_q   <= 32'd0;
            out_inexact_q <= 1'b0;
            out_zero_q    <= 1'b0;
`ifdef INT2FLOAT_FAST_NORM_EN
            lzc_q         <= 6'd0;
            norm_done_q   <= 1'b0;
`endif
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (hs_in) begin
                    sign_q <= sign_in;
                    mag_q  <= mag_in;
                    exp_q  <= 8'd158;
`ifdef INT2FLOAT_FAST_NORM_EN
                    lzc_q       <= lzc_in;
                    norm_done_q <= 1'b0;
`endif
                    if (mag_in == 32'd0) begin
                        out_float_q   <= 32'd0;
                        out_inexact_q <= 1'b0;
                        out_zero_q    <= 1'b1;
                    end
                end
`ifdef INT2FLOAT_FAST_NORM_EN
                // Shift in one go, then spend a cycle so latency stays fixed.
                NORM: if (!norm_done_q) begin
                    mag_q       <= mag_q << lzc_q;
                    exp_q       <= 8'd158 - {2'b00, lzc_q};
                    norm_done_q <= 1'b1;
                end
`else
                NORM: if (!mag_q[31]) begin
                    mag_q <= mag_q << 1;
                    exp_q <= exp_q - 8'd1;
                end
`endif
                ROUND: begin
                    out_float_q   <= {sign_q, exp_r, man_r};
                    out_inexact_q <= g | s;
                    out_zero_q    <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_int2float_seq.sv
// Randomised + directed bench for int2float_seq; RNE and RTZ instances share stimulus.
module tb_int2float_seq;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_signed, out_ready;
    logic [31:0] in_int;
    int          n_cmp = 0;
    int          n_bad = 0;

`ifdef INT2FLOAT_FAST_NORM_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    always #5 clk = ~clk;

    int2float_seq_if if0 ();
    int2float_seq_if if1 ();

    assign if0.in_valid  = in_valid;
    assign if0.in_int    = in_int;
    assign if0.in_signed = in_signed;
    assign if0.out_ready = out_ready;
    assign if1.in_valid  = in_valid;
    assign if1.in_int    = in_int;
    assign if1.in_signed = in_signed;
    assign if1.out_ready = out_ready;

    int2float_seq #(.ROUND_MODE(0)) dut_rne (.clk(clk), .rst_n(rst_n), .bus(if0));
    int2float_seq #(.ROUND_MODE(1)) dut_rtz (.clk(clk), .rst_n(rst_n), .bus(if1));

    // Reference: exact integer magnitude, pick the top 24 bits, round the remainder arithmetically.
    function automatic logic [33:0] model(input logic [31:0] v, input logic sg, input bit rtz);
        logic   neg;
        longint m, q, rem, half;
        int     p, sh;
        logic [7:0] e;
        neg = sg & v[31];
        m = neg ? (64'sd4294967296 - longint'(v)) : longint'(v);
        if (m == 0) return {32'd0, 1'b0, 1'b1};
        p = 31;
        while (((m >> p) & 1) == 0) p--;
        rem = 0;
        if (p <= 23) q = m << (23 - p);
        else begin
            sh   = p - 23;
            q    = m >> sh;
            rem  = m - (q << sh);
            half = longint'(1) << (sh - 1);
            if (!rtz && (rem > half || (rem == half && q[0]))) q = q + 1;
            if (q == (longint'(1) << 24)) begin
                q = q >> 1;
                p++;
            end
        end
        e = 8'(127 + p);
        return {neg, e, q[22:0], rem != 0, 1'b0};
    endfunction

    function automatic int lat_model(input logic [31:0] v, input logic sg);
        longint m;
        int     p;
        m = (sg & v[31]) ? (64'sd4294967296 - longint'(v)) : longint'(v);
        if (m == 0) return 0;
        if (FAST) return 3;
        p = 31;
        while (((m >> p) & 1) == 0) p--;
        return 2 + (31 - p);
    endfunction

    // Drives one operand and reports what came back; lat = -1 on timeout.
    task automatic run_conv(input logic [31:0] v, input logic sg, output int lat,
                            output logic [33:0] r0, output logic [33:0] r1, output logic [1:0] post);
        int w;
        lat = -1; r0 = '0; r1 = '0; post = 2'b11;
        @(negedge clk);
        for (w = 0; w < 80 && !if0.in_ready; w++) @(negedge clk);
        if (!if0.in_ready) return;
        in_valid = 1'b1; in_int = v; in_signed = sg;
        @(posedge clk);
        #1 in_valid = 1'b0; in_int = $urandom(); in_signed = 1'($urandom());
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (if0.out_valid) begin
                lat = i;
                break;
            end
        end
        if (lat < 0) return;
        r0 = {if0.out_float, if0.out_inexact, if0.out_zero};
        r1 = {if1.out_float, if1.out_inexact, if1.out_zero};
        @(posedge clk);
        @(negedge clk);
        post = {if0.out_valid, if0.in_ready};
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({if0.in_ready, if0.out_valid, if0.out_float, if0.out_inexact, if0.out_zero,
             if1.in_ready, if1.out_valid, if1.out_float, if1.out_inexact, if1.out_zero} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h/%h want all zero",
                     {if0.in_ready, if0.out_valid, if0.out_float, if0.out_inexact, if0.out_zero},
                     {if1.in_ready, if1.out_valid, if1.out_float, if1.out_inexact, if1.out_zero});
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (if0.in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_release_ready: got %b want 1", if0.in_ready);
        end
    endtask

    task automatic test_directed;
        logic [31:0] vals [7] = '{32'h00000005, 32'hFFFFFF98, 32'h80000000, 32'h80000000,
                                  32'h00000000, 32'h01000001, 32'hFFFFFFFF};
        logic        sgs  [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [33:0] rne  [7] = '{{32'h40A00000, 2'b00}, {32'hC2D00000, 2'b00}, {32'hCF000000, 2'b00},
                                  {32'h4F000000, 2'b00}, {32'h00000000, 2'b01}, {32'h4B800000, 2'b10},
                                  {32'h4F800000, 2'b10}};
        int          lat;
        logic [33:0] r0, r1;
        logic [1:0]  post;
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            run_conv(vals[i], sgs[i], lat, r0, r1, post);
            n_cmp++;
            if (r0 !== rne[i]) begin
                n_bad++;
                $display("FAIL directed_rne[%0d]: got %h want %h", i, r0, rne[i]);
            end
            n_cmp++;
            if (r1 !== model(vals[i], sgs[i], 1'b1)) begin
                n_bad++;
                $display("FAIL directed_rtz[%0d]: got %h want %h", i, r1, model(vals[i], sgs[i], 1'b1));
            end
            n_cmp++;
            if (lat !== lat_model(vals[i], sgs[i])) begin
                n_bad++;
                $display("FAIL directed_latency[%0d]: got %0d want %0d", i, lat, lat_model(vals[i], sgs[i]));
            end
            n_cmp++;
            if (post !== 2'b01) begin
                n_bad++;
                $display("FAIL directed_release[%0d]: got valid/ready %b want 01", i, post);
            end
        end
        n_cmp++;
        if (r1 !== {32'h4F7FFFFF, 2'b10}) begin
            n_bad++;
            $display("FAIL rtz_all_ones: got %h want %h", r1, {32'h4F7FFFFF, 2'b10});
        end
    endtask

    task automatic test_random;
        logic [31:0] v;
        logic        sg;
        int          lat;
        logic [33:0] r0, r1;
        logic [1:0]  post;
        out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            v  = $urandom() >> $urandom_range(0, 31);
            sg = 1'($urandom());
            run_conv(v, sg, lat, r0, r1, post);
            n_cmp++;
            if ({r0, r1, post} !== {model(v, sg, 1'b0), model(v, sg, 1'b1), 2'b01} ||
                lat !== lat_model(v, sg)) begin
                n_bad++;
                $display("FAIL random[%0d] in=%h s=%b: got %h/%h lat %0d want %h/%h lat %0d",
                         i, v, sg, r0, r1, lat, model(v, sg, 1'b0), model(v, sg, 1'b1), lat_model(v, sg));
            end
        end
    endtask

    task automatic test_backpressure;
        int          lat;
        logic [33:0] r0, r1, exp0;
        logic [1:0]  post;
        exp0 = model(32'h00012345, 1'b0, 1'b0);
        out_ready = 1'b0;
        run_conv(32'h00012345, 1'b0, lat, r0, r1, post);
        n_cmp++;
        if (r0 !== exp0 || post !== 2'b10) begin
            n_bad++;
            $display("FAIL backpressure_hold: got %h post %b want %h post 10", r0, post, exp0);
        end
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_int = $urandom(); in_signed = 1'($urandom());
            @(negedge clk);
            n_cmp++;
            if ({if0.out_valid, if0.in_ready, if0.out_float, if0.out_inexact, if0.out_zero} !== {2'b10, exp0}) begin
                n_bad++;
                $display("FAIL backpressure_stable[%0d]: got %h want %h", i,
                         {if0.out_valid, if0.in_ready, if0.out_float, if0.out_inexact, if0.out_zero}, {2'b10, exp0});
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({if0.out_valid, if0.in_ready} !== 2'b01) begin
            n_bad++;
            $display("FAIL backpressure_release: got %b want 01", {if0.out_valid, if0.in_ready});
        end
        run_conv(32'hFFFF8000, 1'b1, lat, r0, r1, post);
        n_cmp++;
        if (r0 !== {32'hC7000000, 2'b00} || lat !== lat_model(32'hFFFF8000, 1'b1)) begin
            n_bad++;
            $display("FAIL backpressure_next: got %h lat %0d want %h lat %0d",
                     r0, lat, {32'hC7000000, 2'b00}, lat_model(32'hFFFF8000, 1'b1));
        end
    endtask

    task automatic test_reset_mid_norm;
        int          lat;
        logic [33:0] r0, r1;
        logic [1:0]  post;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b1; in_int = 32'd1; in_signed = 1'b0;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({if0.in_ready, if0.out_valid, if0.out_float, if0.out_inexact, if0.out_zero} !== '0) begin
            n_bad++;
            $display("FAIL reset_mid_norm_clear: got %h want 0",
                     {if0.in_ready, if0.out_valid, if0.out_float, if0.out_inexact, if0.out_zero});
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({if0.in_ready, if0.out_valid} !== 2'b10) begin
            n_bad++;
            $display("FAIL reset_mid_norm_ready: got %b want 10", {if0.in_ready, if0.out_valid});
        end
        run_conv(32'd1, 1'b0, lat, r0, r1, post);
        n_cmp++;
        if (r0 !== {32'h3F800000, 2'b00} || r1 !== {32'h3F800000, 2'b00}) begin
            n_bad++;
            $display("FAIL reset_mid_norm_next: got %h/%h want %h", r0, r1, {32'h3F800000, 2'b00});
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_int = '0; in_signed = 1'b0; out_ready = 1'b1;
        test_reset;
        test_directed;
        test_random;
        test_backpressure;
        test_reset_mid_norm;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/int2float_seq.md
Name: int2float_seq

Overview:
Sequential 32-bit integer to IEEE-754 single-precision converter, the inverse stage to float2int. It sits on the ALU conversion path and feeds float operands to the FP arithmetic units. It is a multi-cycle iterative engine with a valid/ready handshake on both the input and output sides. Normalisation uses one shift per cycle; rounding is done in a dedicated cycle.

Parameters:
ROUND_MODE, 0, rounding mode: 0 = round-to-nearest-even, 1 = round-toward-zero; any other value is treated as 0.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  synchronous active-low reset
in_valid  input  1  in_int/in_signed are valid
in_ready  output  1  converter can accept an operand
in_int  input  32  integer operand
in_signed  input  1  1 = two's complement, 0 = unsigned
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_float  output  32  IEEE-754 single result
out_inexact  output  1  result was rounded (guard|sticky nonzero)
out_zero  output  1  result is +0.0

Behaviour:
- Reset: rst_n is sampled on the clk rising edge. It forces state to IDLE. All outputs reset to 0: in_ready, out_valid, out_float, out_inexact, out_zero. A conversion in flight is discarded.
- in_ready is 1 only in IDLE and rst_n high. Input handshake = in_valid & in_ready.
- Output handshake = out_valid & out_ready. out_float, out_inexact and out_zero are stable while out_valid=1.
- FSM states: IDLE, NORM, ROUND, DONE.
- IDLE, on handshake:
  - sign = in_signed & in_int[31].
  - mag (32-bit) = sign ? (~in_int + 1) : in_int. For 0x80000000 signed, mag = 0x80000000 exactly.
  - exp (8-bit) = 158.
  - mag==0 -> DONE with out_float=0x00000000, out_zero=1, out_inexact=0. Otherwise -> NORM.
- NORM: if mag[31]=1 -> ROUND; else mag <<= 1, exp -= 1, stay in NORM. This takes at most 31 shift cycles.
- ROUND:
  - man = mag[30:8], g = mag[7], s = |mag[6:0].
  - RNE increments when g & (s | man[0]); RTZ never increments.
  - A mantissa carry-out sets man=0 and exp+1. Max exp is 159, so no overflow or inf is possible.
  - out_float = {sign, exp, man}; out_inexact = g|s; out_zero = 0. -> DONE.
- DONE: out_valid=1. On output handshake: out_valid drops on the next edge, state -> IDLE, and in_ready=1 on that next cycle. No new operand is accepted in the same cycle.
- Latency (handshake at edge T):
  - Nonzero operand with k leading zeros in mag: out_valid=1 in the cycle after edge T+2+k.
  - Zero operand: out_valid=1 after edge T.
- Throughput: one conversion in flight; no overlap.
- Input changes while not in IDLE are ignored.
- out_valid is held indefinitely under out_ready=0.
- rst_n low mid-NORM or mid-DONE: outputs clear on that edge; the operand is lost.

Optional Feature:
- Macro: INT2FLOAT_FAST_NORM_EN.
- Defined:
  - IDLE computes a 32-bit leading-zero count combinationally.
  - NORM is a single cycle: mag <<= lzc, exp = 158 - lzc.
  - Fixed latency: nonzero result valid after edge T+3; zero after T.
  - Results and flags are bit-identical to the iterative mode.
- Undefined: iterative 1-bit-per-cycle NORM as specified above.

Test Plan:
- Unsigned 0x00000005, out_ready=1 -> 0x40A00000, inexact=0. out_valid after edge T+31 (iterative) or T+3 (fast).
- Signed 0xFFFFFF98 (-104) -> 0xC2D00000, inexact=0. Signed 0x80000000 -> 0xCF000000, inexact=0. in_signed=0 with 0x80000000 -> 0x4F000000.
- Zero: in_int=0 -> 0x00000000, out_zero=1, valid one cycle after handshake. Then 0x01000001 unsigned, ROUND_MODE=0 -> 0x4B800000, inexact=1 (tie to even).
- Rounding: unsigned 0xFFFFFFFF -> 0x4F800000, inexact=1 with ROUND_MODE=0; 0x4F7FFFFF, inexact=1 with ROUND_MODE=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE. out_float must stay stable, in_ready=0, and a new in_valid must be ignored. Release -> IDLE, next operand accepted one cycle later.
- Reset mid-NORM: pull rst_n low 3 cycles after a handshake with operand 1. On that edge all outputs are 0. After release in_ready=1, and the next conversion of 1 gives 0x3F800000.
